// File: rtl/rapid_pkg.sv
// Shared RV32I definitions: instruction classes and major opcodes used by the
// encoder and decoder-side logic.
package rapid_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [3:0] {
      ClsLui    = 4'd0,
      ClsAuipc  = 4'd1,
      ClsJal    = 4'd2,
      ClsJalr   = 4'd3,
      ClsBranch = 4'd4,
      ClsLoad   = 4'd5,
      ClsStore  = 4'd6,
      ClsOpImm  = 4'd7,
      ClsOp     = 4'd8
   } instr_class_e;

   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcOp     = 7'b0110011;

endpackage

// File: rtl/encoder_fifo.sv
// Synchronous FIFO buffering encoded instruction words; head word is shown
// combinationally on o_data while o_valid is high.
module encoder_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 32,
   localparam int unsigned CntW = $clog2(Depth + 1),
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [Width-1:0] i_data,
   input  logic             i_pop,
   output logic [Width-1:0] o_data,
   output logic             o_valid,
   output logic [CntW-1:0]  o_count
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign do_push = i_push && (count_q != CntW'(Depth));
   assign do_pop  = i_pop && (count_q != '0);

   always_comb begin
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
         end
      end
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_valid = (count_q != '0);
   assign o_count = count_q;

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: request register, encode/range-check stage and an
// output FIFO with valid/ready flow control on both sides.
module instr_encoder
   import rapid_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_req_valid,
   output logic                   o_req_ready,
   input  instr_class_e           i_class,
   input  logic [4:0]             i_rd,
   input  logic [4:0]             i_rs1,
   input  logic [4:0]             i_rs2,
   input  logic [2:0]             i_funct3,
   input  logic                   i_iop,
   input  logic signed [XLEN-1:0] i_imm,
   output logic                   o_instr_valid,
   input  logic                   i_instr_ready,
   output logic [XLEN-1:0]        o_instr,
   output logic                   o_err,
   output logic [CntW-1:0]        o_count
);

   logic                   accept;
   logic                   s1_valid_q, s1_valid_d;
   instr_class_e           s1_class_q, s1_class_d;
   logic [4:0]             s1_rd_q, s1_rd_d;
   logic [4:0]             s1_rs1_q, s1_rs1_d;
   logic [4:0]             s1_rs2_q, s1_rs2_d;
   logic [2:0]             s1_funct3_q, s1_funct3_d;
   logic                   s1_iop_q, s1_iop_d;
   logic signed [XLEN-1:0] s1_imm_q, s1_imm_d;

   logic [XLEN-1:0] enc_word;
   logic            reject;
   logic            fits_i, fits_b, fits_j, is_shift;
   logic            push, pop;
   logic [XLEN-1:0] fifo_data;
   logic            fifo_valid;
   logic [CntW-1:0] fifo_count;
   logic [CntW:0]   occupancy;

   assign accept = i_req_valid && o_req_ready;

   always_comb begin
      s1_valid_d  = accept;
      s1_class_d  = s1_class_q;
      s1_rd_d     = s1_rd_q;
      s1_rs1_d    = s1_rs1_q;
      s1_rs2_d    = s1_rs2_q;
      s1_funct3_d = s1_funct3_q;
      s1_iop_d    = s1_iop_q;
      s1_imm_d    = s1_imm_q;
      if (accept) begin
         s1_class_d  = i_class;
         s1_rd_d     = i_rd;
         s1_rs1_d    = i_rs1;
         s1_rs2_d    = i_rs2;
         s1_funct3_d = i_funct3;
         s1_iop_d    = i_iop;
         s1_imm_d    = i_imm;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid_q  <= 1'b0;
         s1_class_q  <= ClsLui;
         s1_rd_q     <= '0;
         s1_rs1_q    <= '0;
         s1_rs2_q    <= '0;
         s1_funct3_q <= '0;
         s1_iop_q    <= 1'b0;
         s1_imm_q    <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_class_q  <= s1_class_d;
         s1_rd_q     <= s1_rd_d;
         s1_rs1_q    <= s1_rs1_d;
         s1_rs2_q    <= s1_rs2_d;
         s1_funct3_q <= s1_funct3_d;
         s1_iop_q    <= s1_iop_d;
         s1_imm_q    <= s1_imm_d;
      end
   end

   // B and J offsets are in units of 2 bytes, so odd offsets are unencodable.
   assign fits_i   = (s1_imm_q >= -2048) && (s1_imm_q <= 2047);
   assign fits_b   = (s1_imm_q >= -4096) && (s1_imm_q <= 4094) && !s1_imm_q[0];
   assign fits_j   = (s1_imm_q >= -1048576) && (s1_imm_q <= 1048574) && !s1_imm_q[0];
   assign is_shift = (s1_funct3_q == 3'b001) || (s1_funct3_q == 3'b101);

   always_comb begin
      enc_word = '0;
      reject   = 1'b0;
      case (s1_class_q)
         ClsLui, ClsAuipc: begin
            reject   = (s1_imm_q[11:0] != 12'd0);
            enc_word = {s1_imm_q[31:12], s1_rd_q,
                        (s1_class_q == ClsLui) ? OpcLui : OpcAuipc};
         end
         ClsJal: begin
            reject   = !fits_j;
            enc_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                        s1_rd_q, OpcJal};
         end
         ClsJalr, ClsLoad: begin
            reject   = !fits_i;
            enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q,
                        (s1_class_q == ClsJalr) ? OpcJalr : OpcLoad};
         end
         ClsOpImm: begin
            if (is_shift) begin
               // Shift amount lives in imm[4:0]; bit 30 selects arithmetic right shift.
               reject   = !fits_i || (s1_imm_q[11:5] != 7'd0);
               enc_word = {1'b0, s1_iop_q & (s1_funct3_q == 3'b101), 5'd0, s1_imm_q[4:0],
                           s1_rs1_q, s1_funct3_q, s1_rd_q, OpcOpImm};
            end else begin
               reject   = !fits_i;
               enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, OpcOpImm};
            end
         end
         ClsStore: begin
            reject   = !fits_i;
            enc_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0],
                        OpcStore};
         end
         ClsBranch: begin
            reject   = !fits_b;
            enc_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                        s1_imm_q[4:1], s1_imm_q[11], OpcBranch};
         end
         ClsOp: begin
            reject   = s1_iop_q && (s1_funct3_q != 3'b000) && (s1_funct3_q != 3'b101);
            enc_word = {1'b0, s1_iop_q, 5'd0, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q,
                        OpcOp};
         end
         default: reject = 1'b1;
      endcase
   end

   assign push = s1_valid_q && !reject;
   assign pop  = fifo_valid && i_instr_ready && !i_rst;

   encoder_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (XLEN)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push),
      .i_data  (enc_word),
      .i_pop   (pop),
      .o_data  (fifo_data),
      .o_valid (fifo_valid),
      .o_count (fifo_count)
   );

   // Reserve a slot for the word still in stage 1 so the FIFO can never overflow.
   assign occupancy     = {1'b0, fifo_count} + {{CntW{1'b0}}, s1_valid_q};
   assign o_req_ready   = !i_rst && (occupancy < (CntW + 1)'(FIFO_DEPTH));
   assign o_err         = !i_rst && s1_valid_q && reject;
   assign o_instr_valid = !i_rst && fifo_valid;
   assign o_instr       = i_rst ? '0 : fifo_data;
   assign o_count       = i_rst ? '0 : fifo_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: an arithmetic RV32I encoding model feeds a
// scoreboard queue that is compared against every word popped from the DUT.
module tb_instr_encoder;
   import rapid_pkg::*;

   logic                   i_clk;
   logic                   i_rst;
   logic                   i_req_valid;
   logic                   o_req_ready;
   instr_class_e           i_class;
   logic [4:0]             i_rd, i_rs1, i_rs2;
   logic [2:0]             i_funct3;
   logic                   i_iop;
   logic signed [XLEN-1:0] i_imm;
   logic                   o_instr_valid;
   logic                   i_instr_ready;
   logic [XLEN-1:0]        o_instr;
   logic                   o_err;
   logic [2:0]             o_count;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned exp_err  = 0;
   int unsigned err_seen = 0;
   logic [31:0] exp_q [$];
   bit          rand_ready = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_word  = '0;
   int opc_tab [9] = '{'h37, 'h17, 'h6F, 'h67, 'h63, 'h03, 'h23, 'h13, 'h33};
   int bnd_tab [18] = '{-4097, -4096, -4095, -2049, -2048, 2047, 2048, 4094, 4095, 4096,
                        -1048576, 1048574, 1048576, 1048575, -1048578, 0, 31, 32};

   instr_encoder #(
      .FIFO_DEPTH (4)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_req_valid   (i_req_valid),
      .o_req_ready   (o_req_ready),
      .i_class       (i_class),
      .i_rd          (i_rd),
      .i_rs1         (i_rs1),
      .i_rs2         (i_rs2),
      .i_funct3      (i_funct3),
      .i_iop         (i_iop),
      .i_imm         (i_imm),
      .o_instr_valid (o_instr_valid),
      .i_instr_ready (i_instr_ready),
      .o_instr       (o_instr),
      .o_err         (o_err),
      .o_count       (o_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
      return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
   endfunction

   // Reference: field placement by shifts, legality by integer ranges.
   function automatic void ref_encode(input int cls, input int rd, input int rs1,
                                      input int rs2, input int f3, input int iop,
                                      input int imm, output logic [31:0] w, output bit rej);
      logic [31:0] u;
      int          opc;
      u   = imm;
      w   = '0;
      rej = 1'b0;
      if (cls > 8) begin
         rej = 1'b1;
         return;
      end
      opc = opc_tab[cls];
      case (cls)
         0, 1: begin
            rej = (imm % 4096) != 0;
            w   = (u & 32'hFFFFF000) | (rd << 7) | opc;
         end
         2: begin
            rej = (imm < -1048576) || (imm > 1048574) || (imm % 2 != 0);
            w   = (fld(u, 20, 20) << 31) | (fld(u, 10, 1) << 21) | (fld(u, 11, 11) << 20)
                | (fld(u, 19, 12) << 12) | (rd << 7) | opc;
         end
         3, 5: begin
            rej = (imm < -2048) || (imm > 2047);
            w   = (fld(u, 11, 0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
         end
         7: begin
            if (f3 == 1 || f3 == 5) begin
               rej = (imm < 0) || (imm > 31);
               w   = (((f3 == 5) && (iop != 0)) ? (1 << 30) : 0) | (fld(u, 4, 0) << 20)
                   | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
            end else begin
               rej = (imm < -2048) || (imm > 2047);
               w   = (fld(u, 11, 0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
            end
         end
         6: begin
            rej = (imm < -2048) || (imm > 2047);
            w   = (fld(u, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                | (fld(u, 4, 0) << 7) | opc;
         end
         4: begin
            rej = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
            w   = (fld(u, 12, 12) << 31) | (fld(u, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15)
                | (f3 << 12) | (fld(u, 4, 1) << 8) | (fld(u, 11, 11) << 7) | opc;
         end
         default: begin
            rej = (iop != 0) && (f3 != 0) && (f3 != 5);
            w   = (iop << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
         end
      endcase
   endfunction

   task automatic drive(input int cls, input int rd, input int rs1, input int rs2,
                        input int f3, input int iop, input int imm);
      logic [3:0] c;
      c        = cls[3:0];
      i_class  = instr_class_e'(c);
      i_rd     = rd[4:0];
      i_rs1    = rs1[4:0];
      i_rs2    = rs2[4:0];
      i_funct3 = f3[2:0];
      i_iop    = iop[0];
      i_imm    = imm;
   endtask

   // Call at posedge+#1; returns at posedge+#1 after the accepting edge.
   task automatic send(input int cls, input int rd, input int rs1, input int rs2,
                       input int f3, input int iop, input int imm,
                       input logic [31:0] ew, input bit erej);
      int w = 0;
      drive(cls, rd, rs1, rs2, f3, iop, imm);
      i_req_valid = 1'b1;
      @(negedge i_clk);
      while (!o_req_ready && w < 200) begin
         @(negedge i_clk);
         w++;
      end
      if (!o_req_ready) begin
         check_eq("send_timeout", 32'(o_req_ready), 32'd1);
         @(posedge i_clk);
      end else begin
         @(posedge i_clk);
         if (erej) exp_err++;
         else exp_q.push_back(ew);
      end
      #1;
      i_req_valid = 1'b0;
   endtask

   task automatic send_model(input int cls, input int rd, input int rs1, input int rs2,
                             input int f3, input int iop, input int imm);
      logic [31:0] w;
      bit          r;
      ref_encode(cls, rd, rs1, rs2, f3, iop, imm, w, r);
      send(cls, rd, rs1, rs2, f3, iop, imm, w, r);
   endtask

   task automatic drain(input string tag);
      int w = 0;
      rand_ready = 0;
      @(posedge i_clk);
      #2;
      i_instr_ready = 1'b1;
      while (exp_q.size() != 0 && w < 500) begin
         @(posedge i_clk);
         w++;
      end
      #1;
      check_eq(tag, exp_q.size(), 32'd0);
   endtask

   function automatic int pick_imm();
      case ($urandom_range(0, 3))
         0:       return int'($urandom_range(0, 80)) - 40;
         1:       return bnd_tab[$urandom_range(0, 17)];
         2:       return int'($urandom());
         default: return int'($urandom() & 32'hFFFFF000);
      endcase
   endfunction

   // Scoreboard and stall-stability monitor.
   initial begin
      forever begin
         @(negedge i_clk);
         if (o_err) err_seen++;
         if (prev_stall && !i_rst) begin
            check_eq("hold_valid", 32'(o_instr_valid), 32'd1);
            check_eq("hold_word", o_instr, prev_word);
         end
         if (o_instr_valid && i_instr_ready) begin
            if (exp_q.size() == 0) check_eq("unexpected_word", 32'(o_instr_valid), 32'd0);
            else check_eq("word", o_instr, exp_q.pop_front());
         end
         prev_stall = o_instr_valid && !i_instr_ready && !i_rst;
         prev_word  = o_instr;
      end
   end

   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         if (rand_ready) i_instr_ready = ($urandom_range(0, 9) < 7);
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int accepted;
      bit acc;
      logic [31:0] w;
      bit r;
      int wt;

      i_rst = 1'b1;
      i_req_valid = 1'b0;
      i_instr_ready = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge i_clk);
      check_eq("rst_valid", 32'(o_instr_valid), 32'd0);
      check_eq("rst_count", 32'(o_count), 32'd0);
      check_eq("rst_err", 32'(o_err), 32'd0);
      check_eq("rst_instr", o_instr, 32'd0);
      check_eq("rst_ready", 32'(o_req_ready), 32'd0);
      @(posedge i_clk);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      check_eq("ready_after_rst", 32'(o_req_ready), 32'd1);
      @(posedge i_clk);
      #1;

      // Two-cycle latency through an empty pipeline.
      i_instr_ready = 1'b1;
      drive(7, 1, 0, 0, 0, 0, 5);
      i_req_valid = 1'b1;
      @(negedge i_clk);
      check_eq("lat_ready", 32'(o_req_ready), 32'd1);
      @(posedge i_clk);
      exp_q.push_back(32'h00500093);
      #1 i_req_valid = 1'b0;
      @(negedge i_clk);
      check_eq("lat1_valid", 32'(o_instr_valid), 32'd0);
      @(negedge i_clk);
      check_eq("lat2_valid", 32'(o_instr_valid), 32'd1);
      check_eq("lat2_word", o_instr, 32'h00500093);
      @(posedge i_clk);
      #1;

      send(0, 2, 0, 0, 0, 0, 32'h12345000, 32'h12345137, 1'b0);
      send(2, 1, 0, 0, 0, 0, 8, 32'h008000EF, 1'b0);
      send(4, 0, 1, 2, 0, 0, 16, 32'h00208863, 1'b0);
      send(7, 3, 3, 0, 5, 1, 2, 32'h4021D193, 1'b0);
      send(8, 5, 6, 7, 0, 1, 0, 32'h407302B3, 1'b0);
      drain("drain_directed");

      // Out-of-range immediate is dropped with a single error pulse.
      @(posedge i_clk);
      #1;
      send(7, 1, 0, 0, 0, 0, 2048, 32'd0, 1'b1);
      @(negedge i_clk);
      check_eq("rej_err", 32'(o_err), 32'd1);
      check_eq("rej_valid", 32'(o_instr_valid), 32'd0);
      check_eq("rej_count", 32'(o_count), 32'd0);
      @(negedge i_clk);
      check_eq("rej_err_end", 32'(o_err), 32'd0);
      check_eq("rej_valid_end", 32'(o_instr_valid), 32'd0);
      check_eq("rej_count_end", 32'(o_count), 32'd0);
      @(posedge i_clk);
      #1;

      // Back-pressure: six back-to-back requests with the sink stalled.
      i_instr_ready = 1'b0;
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         ref_encode(7, i + 1, i, 0, 0, 0, i * 3, w, r);
         drive(7, i + 1, i, 0, 0, 0, i * 3);
         i_req_valid = 1'b1;
         @(negedge i_clk);
         acc = o_req_ready;
         @(posedge i_clk);
         if (acc) begin
            accepted++;
            exp_q.push_back(w);
         end
         #1;
      end
      i_req_valid = 1'b0;
      check_eq("bp_accepted", accepted, 32'd4);
      @(negedge i_clk);
      check_eq("bp_ready", 32'(o_req_ready), 32'd0);
      check_eq("bp_count", 32'(o_count), 32'd4);
      repeat (3) @(posedge i_clk);
      #1;
      drain("drain_bp");

      rand_ready = 1;
      for (int n = 0; n < 250; n++) begin
         send_model($urandom_range(0, 11), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 1),
                    pick_imm());
         if ($urandom_range(0, 3) == 0) begin
            @(posedge i_clk);
            #1;
         end
      end
      drain("drain_random");

      // Reset with three buffered words and one still in stage 1.
      @(posedge i_clk);
      #1;
      i_instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_model(7, 4 + i, 1, 0, 0, 0, 100 + i);
      wt = 0;
      @(negedge i_clk);
      while (o_count != 3'd3 && wt < 20) begin
         @(negedge i_clk);
         wt++;
      end
      check_eq("pre_rst_count", 32'(o_count), 32'd3);
      @(posedge i_clk);
      #1;
      send_model(7, 9, 2, 0, 0, 0, 77);
      i_rst = 1'b1;
      exp_q.delete();
      @(negedge i_clk);
      check_eq("mid_rst_count", 32'(o_count), 32'd0);
      check_eq("mid_rst_valid", 32'(o_instr_valid), 32'd0);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      check_eq("post_rst_ready", 32'(o_req_ready), 32'd1);
      check_eq("post_rst_count", 32'(o_count), 32'd0);
      i_instr_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge i_clk);
         check_eq("post_rst_valid", 32'(o_instr_valid), 32'd0);
      end

      check_eq("err_total", err_seen, exp_err);
      check_eq("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port: i_clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: i_rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: i_req_valid in 1, o_req_ready out 1 (request valid/ready handshake).
REQ-004 SHALL have ports: i_class in instr_class_e (4), i_rd/i_rs1/i_rs2 in 5 each, i_funct3 in 3, i_iop in 1, i_imm in XLEN signed.
REQ-005 SHALL have ports: o_instr_valid out 1, i_instr_ready in 1, o_instr out XLEN (encoded RV32I word).
REQ-006 SHALL have ports: o_err out 1 (one-cycle reject pulse), o_count out 3 (output FIFO occupancy, 0..4).
REQ-007 SHALL have parameter: FIFO_DEPTH, default 4, output buffer depth.

Function
REQ-008 SHALL accept a request on a cycle where i_req_valid and o_req_ready are both high.
REQ-009 SHALL register accepted requests in stage 1; stage 2 encodes, range-checks, and pushes to the FIFO.
REQ-010 SHALL present the word on o_instr/o_instr_valid two cycles after acceptance when the FIFO is empty.
REQ-011 SHALL drive o_req_ready = (o_count + in-flight stage entries) < FIFO_DEPTH; FIFO never overflows.
REQ-012 SHALL pop on o_instr_valid and i_instr_ready high; simultaneous push and pop leaves o_count unchanged.
REQ-013 SHALL hold o_instr stable while o_instr_valid is high and i_instr_ready is low.
REQ-014 SHALL use opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011.
REQ-015 SHALL place immediates per RV32I U/J/I/B/S formats; rd, rs1, rs2, funct3 in standard bit fields.
REQ-016 SHALL reject a U-type whose i_imm[11:0] is non-zero.
REQ-017 SHALL reject an I/S-type whose i_imm lies outside -2048..2047.
REQ-018 SHALL reject a B-type outside -4096..4094, and a J-type outside -2^20..2^20-2, and either with i_imm[0]=1.
REQ-019 SHALL, for OP_IMM with funct3 001/101, require i_imm[11:5]=0, and set bit30 = i_iop only for funct3 101.
REQ-020 SHALL, for OP, set bit30 = i_iop, rejecting i_iop=1 unless funct3 is 000 or 101.
REQ-021 SHALL reject undefined i_class values.
REQ-022 SHALL, on any reject, drop the word, never push it, and pulse o_err for exactly the stage-2 cycle.

Reset
REQ-023 SHALL, on i_rst high at a clock edge, clear both stages and the FIFO: o_instr_valid=0, o_count=0, o_err=0, o_instr=0, o_req_ready=0 during reset.
REQ-024 SHALL discard in-flight and buffered words on reset mid-operation, and assert o_req_ready the first cycle after i_rst deasserts.

Structure
REQ-025 SHALL define instr_class_e and the opcode constants in rapid_pkg, shared with decoder-side logic; XLEN is taken from rapid_pkg.
REQ-026 SHALL implement the output buffer as sub-module encoder_fifo (synchronous FIFO, push/pop/count); all encoding stays in instr_encoder.

Verification
REQ-027 SHALL cover: OP_IMM rd=1 rs1=0 f3=000 imm=5 -> 0x00500093, two cycles after acceptance.
REQ-028 SHALL cover: LUI rd=2 imm=0x12345000 -> 0x12345137; JAL rd=1 imm=8 -> 0x008000EF.
REQ-029 SHALL cover: BRANCH rs1=1 rs2=2 f3=000 imm=16 -> 0x00208863; OP_IMM SRAI rd=3 rs1=3 imm=2 iop=1 -> 0x4021D193; OP SUB rd=5 rs1=6 rs2=7 iop=1 -> 0x407302B3.
REQ-030 SHALL cover: OP_IMM imm=2048 -> single o_err pulse, no o_instr_valid, o_count unchanged.
REQ-031 SHALL cover: i_instr_ready=0 with 6 back-to-back requests -> exactly 4 accepted, o_req_ready=0, o_count=4; releasing ready drains them in order.
REQ-032 SHALL cover: i_rst pulse with o_count=3 and one in-flight request -> o_count=0, no stale word emitted after reset.
